// File: rtl/uart_ram_sequencer.sv
// Moves UART RX bytes into RAM, hands RAM to the CPU, then streams a result
// window from RAM back to the UART transmitter one byte per TX_DONE.
module uart_ram_sequencer #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int RX_BYTES    = 256,
  parameter int TX_BASE     = 0,
  parameter int TX_BYTES    = 256,
  parameter int RAM_LATENCY = 2
) (
  input  logic                  MAIN_CLOCK,
  input  logic                  RESET,
  input  logic                  RX_VALID,
  input  logic [DATA_WIDTH-1:0] RX_DATA,
  input  logic                  TX_DONE,
  input  logic                  PROCESS_FINISHED,
  input  logic [DATA_WIDTH-1:0] RAM_Q,
  output logic [ADDR_WIDTH-1:0] RAM_ADDRESS,
  output logic [DATA_WIDTH-1:0] RAM_DATA,
  output logic                  RAM_WREN,
  output logic                  START_PROCESSING,
  output logic                  LOAD_COMPLETE,
  output logic                  TX_START,
  output logic [DATA_WIDTH-1:0] TX_DATA,
  output logic [2:0]            STATE
);

  typedef enum logic [2:0] {
    ST_LOAD    = 3'd0,
    ST_PROCESS = 3'd1,
    ST_FETCH   = 3'd2,
    ST_WAIT_TX = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  localparam int LW = $clog2(RAM_LATENCY + 2);

  localparam logic [ADDR_WIDTH:0]   RX_LAST   = (ADDR_WIDTH+1)'(RX_BYTES - 1);
  localparam logic [ADDR_WIDTH:0]   TX_END    = (ADDR_WIDTH+1)'(TX_BYTES);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] TX_BASE_A = ADDR_WIDTH'(TX_BASE);
  localparam logic [LW-1:0]         LAT_LAST  = LW'(RAM_LATENCY);
  localparam logic [LW-1:0]         LAT_ONE   = LW'(1);

  // Handshakes: RX_VALID, TX_DONE and TX_START are single-cycle pulses with no
  // back-pressure; a pulse arriving in a state that does not expect it is dropped.

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   rx_count_q, rx_count_d;
  logic [ADDR_WIDTH:0]   tx_idx_q, tx_idx_d;
  logic [ADDR_WIDTH:0]   tx_idx_inc;
  logic [LW-1:0]         lat_q, lat_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  wren_q, wren_d;
  logic                  start_q, start_d;
  logic                  load_complete_q, load_complete_d;
  logic                  tx_start_q, tx_start_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;

  assign tx_idx_inc = tx_idx_q + CNT_ONE;

  always_ff @(posedge MAIN_CLOCK) begin
    if (RESET) begin
      state_q         <= ST_LOAD;
      rx_count_q      <= '0;
      tx_idx_q        <= '0;
      lat_q           <= '0;
      addr_q          <= '0;
      wdata_q         <= '0;
      wren_q          <= 1'b0;
      start_q         <= 1'b0;
      load_complete_q <= 1'b0;
      tx_start_q      <= 1'b0;
      tx_data_q       <= '0;
    end else begin
      state_q         <= state_d;
      rx_count_q      <= rx_count_d;
      tx_idx_q        <= tx_idx_d;
      lat_q           <= lat_d;
      addr_q          <= addr_d;
      wdata_q         <= wdata_d;
      wren_q          <= wren_d;
      start_q         <= start_d;
      load_complete_q <= load_complete_d;
      tx_start_q      <= tx_start_d;
      tx_data_q       <= tx_data_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    rx_count_d      = rx_count_q;
    tx_idx_d        = tx_idx_q;
    lat_d           = lat_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    wren_d          = 1'b0;
    start_d         = start_q;
    load_complete_d = load_complete_q;
    tx_start_d      = 1'b0;
    tx_data_d       = tx_data_q;

    case (state_q)
      ST_LOAD: begin
        if (RX_VALID) begin
          addr_d     = rx_count_q[ADDR_WIDTH-1:0];
          wdata_d    = RX_DATA;
          wren_d     = 1'b1;
          rx_count_d = rx_count_q + CNT_ONE;
          if (rx_count_q == RX_LAST) begin
            load_complete_d = 1'b1;
            start_d         = 1'b1;
            state_d         = ST_PROCESS;
          end
        end
      end

      ST_PROCESS: begin
        addr_d  = '0;
        wdata_d = '0;
        start_d = 1'b1;
        if (PROCESS_FINISHED) begin
          start_d  = 1'b0;
          tx_idx_d = '0;
          lat_d    = '0;
          addr_d   = TX_BASE_A;
          state_d  = ST_FETCH;
        end
      end

      // The address is registered on FETCH entry, so after RAM_LATENCY edges in
      // FETCH the RAM read data is valid and the following edge captures it.
      ST_FETCH: begin
        addr_d = TX_BASE_A + tx_idx_q[ADDR_WIDTH-1:0];
        if (lat_q == LAT_LAST) begin
          tx_data_d  = RAM_Q;
          tx_start_d = 1'b1;
          state_d    = ST_WAIT_TX;
        end else begin
          lat_d = lat_q + LAT_ONE;
        end
      end

      ST_WAIT_TX: begin
        if (TX_DONE) begin
          tx_idx_d = tx_idx_inc;
          lat_d    = '0;
          if (tx_idx_inc == TX_END) begin
            state_d = ST_DONE;
          end else begin
            addr_d  = TX_BASE_A + tx_idx_inc[ADDR_WIDTH-1:0];
            state_d = ST_FETCH;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_DONE;
      end

      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  assign RAM_ADDRESS      = addr_q;
  assign RAM_DATA         = wdata_q;
  assign RAM_WREN         = wren_q;
  assign START_PROCESSING = start_q;
  assign LOAD_COMPLETE    = load_complete_q;
  assign TX_START         = tx_start_q;
  assign TX_DATA          = tx_data_q;
  assign STATE            = state_q;

endmodule

// File: tb/tb_uart_ram_sequencer.sv
// Directed bench for uart_ram_sequencer: a small-window instance with a 2-cycle
// behavioural RAM, plus a 2-bit-address instance exercising address wrap.
module tb_uart_ram_sequencer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // ---------------- main instance ----------------
  logic        rst, rx_valid, tx_done, proc_fin;
  logic [7:0]  rx_data, ram_q, ram_data, tx_data;
  logic [15:0] ram_address;
  logic        ram_wren, start_proc, load_complete, tx_start;
  logic [2:0]  state;

  uart_ram_sequencer #(
    .ADDR_WIDTH(16), .DATA_WIDTH(8), .RX_BYTES(4),
    .TX_BASE(2), .TX_BYTES(3), .RAM_LATENCY(2)
  ) dut (
    .MAIN_CLOCK(clk), .RESET(rst), .RX_VALID(rx_valid), .RX_DATA(rx_data),
    .TX_DONE(tx_done), .PROCESS_FINISHED(proc_fin), .RAM_Q(ram_q),
    .RAM_ADDRESS(ram_address), .RAM_DATA(ram_data), .RAM_WREN(ram_wren),
    .START_PROCESSING(start_proc), .LOAD_COMPLETE(load_complete),
    .TX_START(tx_start), .TX_DATA(tx_data), .STATE(state)
  );

  logic [7:0]  mem [0:65535];
  logic [15:0] ram_addr_r;
  logic        pre_we = 1'b0;
  logic [15:0] pre_addr = '0;
  logic [7:0]  pre_data = '0;

  always @(posedge clk) begin
    if (ram_wren) mem[ram_address] <= ram_data;
    else if (pre_we) mem[pre_addr] <= pre_data;
    ram_addr_r <= ram_address;
    ram_q      <= mem[ram_addr_r];
  end

  // ---------------- wrap instance ----------------
  logic       w_rst, w_rx_valid, w_tx_done, w_fin;
  logic [7:0] w_rx_data, w_ram_q, w_ram_data, w_tx_data;
  logic [1:0] w_ram_address;
  logic       w_ram_wren, w_start, w_lc, w_tx_start;
  logic [2:0] w_state;

  uart_ram_sequencer #(
    .ADDR_WIDTH(2), .DATA_WIDTH(8), .RX_BYTES(4),
    .TX_BASE(3), .TX_BYTES(2), .RAM_LATENCY(2)
  ) dut_w (
    .MAIN_CLOCK(clk), .RESET(w_rst), .RX_VALID(w_rx_valid), .RX_DATA(w_rx_data),
    .TX_DONE(w_tx_done), .PROCESS_FINISHED(w_fin), .RAM_Q(w_ram_q),
    .RAM_ADDRESS(w_ram_address), .RAM_DATA(w_ram_data), .RAM_WREN(w_ram_wren),
    .START_PROCESSING(w_start), .LOAD_COMPLETE(w_lc),
    .TX_START(w_tx_start), .TX_DATA(w_tx_data), .STATE(w_state)
  );

  logic [7:0] w_mem [0:3];
  logic [1:0] w_addr_r;

  always @(posedge clk) begin
    if (w_ram_wren) w_mem[w_ram_address] <= w_ram_data;
    w_addr_r <= w_ram_address;
    w_ram_q  <= w_mem[w_addr_r];
  end

  logic [7:0] exp_q[$];

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tx_start(output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!tx_start && cyc < 20);
  endtask

  task automatic send_rx(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; rx_valid = 1'b0; rx_data = '0; tx_done = 1'b0; proc_fin = 1'b0;
    pre_we = 1'b1; pre_addr = 16'd4; pre_data = 8'h5A;
    tick();
    pre_we = 1'b0;
    tick();
    n_vec++; if (state !== 3'd0) begin n_err++; $display("FAIL reset_state: got %0d expected 0", state); end
    n_vec++;
    if ({ram_address, ram_data, ram_wren, start_proc, load_complete, tx_start, tx_data} !== 36'd0) begin
      n_err++;
      $display("FAIL reset_outputs: addr=%h data=%h wren=%b start=%b lc=%b txs=%b txd=%h expected all 0",
               ram_address, ram_data, ram_wren, start_proc, load_complete, tx_start, tx_data);
    end
    rst = 1'b0;
  endtask

  task automatic test_load();
    logic [7:0] b [4];
    b = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
    for (int i = 0; i < 4; i++) begin
      rx_valid = 1'b1;
      rx_data  = b[i];
      tick();
      rx_valid = 1'b0;
      n_vec++; if (ram_wren !== 1'b1) begin n_err++; $display("FAIL load_wren[%0d]: got %b expected 1", i, ram_wren); end
      n_vec++; if (ram_address !== 16'(i)) begin n_err++; $display("FAIL load_addr[%0d]: got %h expected %h", i, ram_address, 16'(i)); end
      n_vec++; if (ram_data !== b[i]) begin n_err++; $display("FAIL load_data[%0d]: got %h expected %h", i, ram_data, b[i]); end
      n_vec++; if (load_complete !== (i == 3)) begin n_err++; $display("FAIL load_complete[%0d]: got %b expected %b", i, load_complete, (i == 3)); end
      n_vec++; if (state !== ((i == 3) ? 3'd1 : 3'd0)) begin n_err++; $display("FAIL load_state[%0d]: got %0d", i, state); end
      n_vec++; if (start_proc !== (i == 3)) begin n_err++; $display("FAIL load_start[%0d]: got %b expected %b", i, start_proc, (i == 3)); end
      repeat (i + 1) tick();
      n_vec++; if (ram_wren !== 1'b0) begin n_err++; $display("FAIL load_wren_single[%0d]: got %b expected 0", i, ram_wren); end
    end
    n_vec++; if ({ram_address, ram_data} !== 24'd0) begin n_err++; $display("FAIL process_ram_idle: addr=%h data=%h expected 0", ram_address, ram_data); end
    n_vec++; if (start_proc !== 1'b1 || state !== 3'd1) begin n_err++; $display("FAIL process_hold: start=%b state=%0d expected 1/1", start_proc, state); end
    for (int i = 0; i < 4; i++) begin
      n_vec++; if (mem[i] !== b[i]) begin n_err++; $display("FAIL load_mem[%0d]: got %h expected %h", i, mem[i], b[i]); end
    end
  endtask

  task automatic test_stray_process();
    rx_valid = 1'b1; rx_data = 8'hEE; tx_done = 1'b1;
    tick();
    rx_valid = 1'b0; tx_done = 1'b0;
    n_vec++; if (ram_wren !== 1'b0) begin n_err++; $display("FAIL stray_rx_wren: got %b expected 0", ram_wren); end
    n_vec++; if (state !== 3'd1 || start_proc !== 1'b1) begin n_err++; $display("FAIL stray_rx_state: state=%0d start=%b expected 1/1", state, start_proc); end
    tick();
    n_vec++; if (mem[0] !== 8'hA5) begin n_err++; $display("FAIL stray_rx_mem: got %h expected a5", mem[0]); end
  endtask

  task automatic test_unload();
    int cyc, c2, extra;
    logic [7:0] exp_b;
    exp_q = '{8'hFF, 8'h00, 8'h5A};
    proc_fin = 1'b1;
    tick();
    n_vec++; if (start_proc !== 1'b0) begin n_err++; $display("FAIL unload_start_low: got %b expected 0", start_proc); end
    for (int k = 0; k < 3; k++) begin
      n_vec++; if (state !== 3'd2) begin n_err++; $display("FAIL unload_fetch_state[%0d]: got %0d expected 2", k, state); end
      n_vec++; if (ram_address !== 16'(2 + k)) begin n_err++; $display("FAIL unload_addr[%0d]: got %h expected %h", k, ram_address, 16'(2 + k)); end
      n_vec++; if (ram_wren !== 1'b0) begin n_err++; $display("FAIL unload_wren[%0d]: got %b expected 0", k, ram_wren); end
      if (k == 0) begin
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        n_vec++; if (state !== 3'd2 || tx_start !== 1'b0) begin n_err++; $display("FAIL stray_tx_done: state=%0d txs=%b expected 2/0", state, tx_start); end
        wait_tx_start(c2);
        cyc = c2 + 1;
      end else begin
        wait_tx_start(cyc);
      end
      exp_b = exp_q.pop_front();
      n_vec++; if (cyc !== 3) begin n_err++; $display("FAIL tx_start_latency[%0d]: got %0d cycles expected 3", k, cyc); end
      n_vec++; if (tx_data !== exp_b) begin n_err++; $display("FAIL tx_data[%0d]: got %h expected %h", k, tx_data, exp_b); end
      n_vec++; if (state !== 3'd3) begin n_err++; $display("FAIL wait_tx_state[%0d]: got %0d expected 3", k, state); end
      extra = 0;
      repeat (4) begin
        tick();
        if (tx_start) extra++;
      end
      n_vec++; if (extra !== 0) begin n_err++; $display("FAIL tx_start_pulse[%0d]: got %0d extra pulses expected 0", k, extra); end
      n_vec++; if (tx_data !== exp_b) begin n_err++; $display("FAIL tx_data_hold[%0d]: got %h expected %h", k, tx_data, exp_b); end
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
    end
    proc_fin = 1'b0;
    n_vec++; if (state !== 3'd4) begin n_err++; $display("FAIL done_state: got %0d expected 4", state); end
    rx_valid = 1'b1; tx_done = 1'b1; proc_fin = 1'b1;
    tick();
    rx_valid = 1'b0; tx_done = 1'b0; proc_fin = 1'b0;
    tick();
    n_vec++;
    if (state !== 3'd4 || ram_wren !== 1'b0 || tx_start !== 1'b0 || load_complete !== 1'b1 || start_proc !== 1'b0) begin
      n_err++;
      $display("FAIL done_sticky: state=%0d wren=%b txs=%b lc=%b start=%b expected 4/0/0/1/0",
               state, ram_wren, tx_start, load_complete, start_proc);
    end
  endtask

  task automatic test_reset_mid_op();
    int cyc;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    send_rx(8'h01); send_rx(8'h02); send_rx(8'h03); send_rx(8'h04);
    proc_fin = 1'b1;
    tick();
    proc_fin = 1'b0;
    wait_tx_start(cyc);
    repeat (2) tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    wait_tx_start(cyc);
    n_vec++; if (state !== 3'd3 || tx_data !== 8'h04) begin n_err++; $display("FAIL midop_setup: state=%0d txd=%h expected 3/04", state, tx_data); end
    rst = 1'b1; tx_done = 1'b1; rx_valid = 1'b1;
    tick();
    rst = 1'b0; tx_done = 1'b0; rx_valid = 1'b0;
    n_vec++; if (state !== 3'd0) begin n_err++; $display("FAIL midop_state: got %0d expected 0", state); end
    n_vec++;
    if ({ram_address, ram_data, ram_wren, start_proc, load_complete, tx_start, tx_data} !== 36'd0) begin
      n_err++;
      $display("FAIL midop_outputs: addr=%h data=%h wren=%b start=%b lc=%b txs=%b txd=%h expected all 0",
               ram_address, ram_data, ram_wren, start_proc, load_complete, tx_start, tx_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b [4];
    b = '{8'h10, 8'h20, 8'h30, 8'h40};
    for (int i = 0; i < 4; i++) begin
      rx_valid = 1'b1;
      rx_data  = b[i];
      tick();
      n_vec++;
      if (ram_wren !== 1'b1 || ram_address !== 16'(i) || ram_data !== b[i]) begin
        n_err++;
        $display("FAIL b2b_write[%0d]: wren=%b addr=%h data=%h expected 1/%h/%h", i, ram_wren, ram_address, ram_data, 16'(i), b[i]);
      end
    end
    rx_data = 8'h77;
    tick();
    rx_valid = 1'b0;
    n_vec++; if (ram_wren !== 1'b0 || state !== 3'd1) begin n_err++; $display("FAIL b2b_drop_after_load: wren=%b state=%0d expected 0/1", ram_wren, state); end
    tick();
    for (int i = 0; i < 4; i++) begin
      n_vec++; if (mem[i] !== b[i]) begin n_err++; $display("FAIL b2b_mem[%0d]: got %h expected %h", i, mem[i], b[i]); end
    end
    n_vec++; if (mem[4] !== 8'h5A) begin n_err++; $display("FAIL b2b_mem4_untouched: got %h expected 5a", mem[4]); end
  endtask

  task automatic test_wrap();
    int cyc;
    logic [7:0] b [4];
    logic [7:0] exp_tx [2];
    logic [1:0] exp_addr [2];
    b = '{8'h11, 8'h22, 8'h33, 8'h44};
    exp_tx = '{8'h44, 8'h11};
    exp_addr = '{2'd3, 2'd0};
    w_rst = 1'b1;
    tick();
    w_rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      w_rx_valid = 1'b1;
      w_rx_data  = b[i];
      tick();
      n_vec++;
      if (w_ram_wren !== 1'b1 || w_ram_address !== 2'(i)) begin
        n_err++;
        $display("FAIL wrap_load[%0d]: wren=%b addr=%0d expected 1/%0d", i, w_ram_wren, w_ram_address, i);
      end
    end
    w_rx_valid = 1'b0;
    tick();
    w_fin = 1'b1;
    tick();
    w_fin = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_vec++;
      if (w_state !== 3'd2 || w_ram_address !== exp_addr[k]) begin
        n_err++;
        $display("FAIL wrap_fetch_addr[%0d]: state=%0d addr=%0d expected 2/%0d", k, w_state, w_ram_address, exp_addr[k]);
      end
      cyc = 0;
      do begin
        tick();
        cyc++;
      end while (!w_tx_start && cyc < 20);
      n_vec++;
      if (cyc !== 3 || w_tx_data !== exp_tx[k]) begin
        n_err++;
        $display("FAIL wrap_tx[%0d]: cycles=%0d data=%h expected 3/%h", k, cyc, w_tx_data, exp_tx[k]);
      end
      repeat (4) tick();
      w_tx_done = 1'b1;
      tick();
      w_tx_done = 1'b0;
    end
    n_vec++; if (w_state !== 3'd4) begin n_err++; $display("FAIL wrap_done: state=%0d expected 4", w_state); end
  endtask

  initial begin
    w_rst = 1'b1; w_rx_valid = 1'b0; w_rx_data = '0; w_tx_done = 1'b0; w_fin = 1'b0;
    test_reset();
    test_load();
    test_stray_process();
    test_unload();
    test_reset_mid_op();
    test_back_to_back();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
